truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/truth_table_scanner.sv | 105 ++++++++++
 tb/tb_truth_table_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps a 4-bit vector through 0..15 onto A..D, samples the
// downstream block's Y after SETTLE cycles per vector and compares against a golden table.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        Y,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [4:0]  mismatches
);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  vector_q, vector_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic        match_q, match_d;
  logic [4:0]  mism_q, mism_d;

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    match_d  = match_q;
    mism_d   = mism_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDrive;
          vector_d = 4'd0;
          settle_d = 4'd0;
          exp_d    = expected;
          tt_d     = 16'h0000;
          mism_d   = 5'd0;
          match_d  = 1'b0;
        end
      end
      StDrive: begin
        settle_d = settle_q + 4'd1;
        if (settle_q == SettleLast) state_d = StSample;
      end
      StSample: begin
        tt_d[vector_q] = Y;
        if (Y != exp_q[vector_q]) mism_d = mism_q + 5'd1;
        settle_d = 4'd0;
        if (vector_q == 4'd15) begin
          state_d = StDone;
          // Compare against the table including the bit captured on this edge.
          match_d = (tt_d == exp_q);
        end else begin
          state_d  = StDrive;
          vector_d = vector_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      vector_q <= 4'd0;
      settle_q <= 4'd0;
      exp_q    <= 16'h0000;
      tt_q     <= 16'h0000;
      match_q  <= 1'b0;
      mism_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      match_q  <= match_d;
      mism_q   <= mism_d;
    end
  end

  always_comb begin
    busy         = (state_q == StDrive) || (state_q == StSample);
    done         = (state_q == StDone);
    {A, B, C, D} = busy ? vector_q : 4'b0000;
    tt           = tt_q;
    match        = match_q;
    mismatches   = mism_q;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a SETTLE=2 instance driven from a vector table plus
// reset/restart corner sequences, and a SETTLE=1 instance with start held high.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start1;
  logic [15:0] expected, expected1;
  logic [1:0]  y_mode;
  logic        y, y1;
  logic        a, b, c, d, busy, done, match;
  logic        a1, b1, c1, d1, busy1, done1, match1;
  logic [15:0] tt, tt1;
  logic [4:0]  mism, mism1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Downstream combinational block models.
  always_comb begin
    case (y_mode)
      2'd0:    y = a & b;
      2'd1:    y = 1'b0;
      default: y = a ^ b ^ c ^ d;
    endcase
  end
  assign y1 = a1 ^ b1 ^ c1 ^ d1;

  truth_table_scanner #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .Y(y),
    .A(a), .B(b), .C(c), .D(d), .busy(busy), .done(done),
    .tt(tt), .match(match), .mismatches(mism)
  );

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .expected(expected1), .Y(y1),
    .A(a1), .B(b1), .C(c1), .D(d1), .busy(busy1), .done(done1),
    .tt(tt1), .match(match1), .mismatches(mism1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Waits (bounded) for done; lat counts negedges after the edge that accepted start.
  task automatic wait_done(input bit inject7, output int lat);
    bit injected = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      start = inject7 && !injected && busy && ({a, b, c, d} == 4'd7);
      if (start) injected = 1'b1;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] exp;
    logic [15:0] tt;
    logic        match;
    logic [4:0]  mism;
    bit          inject7;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, extra, errs, k;
    vecs[0] = '{2'd0, 16'hF000, 16'hF000, 1'b1, 5'd0,  1'b0};
    vecs[1] = '{2'd1, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 1'b0};
    vecs[2] = '{2'd2, 16'h6996, 16'h6996, 1'b1, 5'd0,  1'b0};
    vecs[3] = '{2'd2, 16'h6997, 16'h6996, 1'b0, 5'd1,  1'b0};
    vecs[4] = '{2'd0, 16'h0000, 16'hF000, 1'b0, 5'd4,  1'b0};
    vecs[5] = '{2'd1, 16'h0000, 16'h0000, 1'b1, 5'd0,  1'b0};
    vecs[6] = '{2'd2, 16'h6996, 16'h6996, 1'b1, 5'd0,  1'b1};

    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    expected = 16'h0; expected1 = 16'h0; y_mode = 2'd0;
    #3;
    check("reset outputs", {a, b, c, d, busy, done, tt, match, mism}, 32'd0);
    check("reset outputs s1", {a1, b1, c1, d1, busy1, done1, tt1, match1, mism1}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      y_mode = vecs[i].mode; expected = vecs[i].exp; start = 1'b1;
      @(negedge clk);
      start = 1'b0; expected = ~vecs[i].exp;  // must not disturb the latched table
      check($sformatf("v%0d busy after start", i), busy, 1'b1);
      wait_done(vecs[i].inject7, lat);
      check($sformatf("v%0d done latency", i), lat, 48);
      check($sformatf("v%0d tt", i), tt, vecs[i].tt);
      check($sformatf("v%0d match", i), match, vecs[i].match);
      check($sformatf("v%0d mismatches", i), mism, vecs[i].mism);
      extra = 0;
      for (int j = 0; j < 60; j++) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check($sformatf("v%0d single done, idle after", i), extra, 0);
      check($sformatf("v%0d results held", i), {tt, match, mism},
            {vecs[i].tt, vecs[i].match, vecs[i].mism});
    end

    // Abort mid-scan with reset at vector 5.
    @(negedge clk);
    y_mode = 2'd2; expected = 16'hF000; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while ({a, b, c, d} != 4'd5 && k < 200) begin @(negedge clk); k++; end
    check("reached vector 5", {busy, a, b, c, d}, {1'b1, 4'd5});
    check("tt nonzero before abort", tt, 16'h0016);
    #2 rst = 1'b1;
    #1 check("async reset clears", {a, b, c, d, busy, done, tt, match, mism}, 32'd0);
    @(negedge clk); rst = 1'b0;
    extra = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("no done after abort", extra, 0);

    // Start coincident with first clock after reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; expected = 16'h6996; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("restart at vector 0", {busy, a, b, c, d}, {1'b1, 4'd0});
    wait_done(1'b0, lat);
    check("restart done latency", lat, 48);
    check("restart match", {match, mism}, {1'b1, 5'd0});

    // SETTLE=1 with start held high: back-to-back scans, fresh latch each time.
    @(negedge clk);
    expected1 = 16'h6996; start1 = 1'b1;
    k = 0;
    while (!done1 && k < 100) begin @(negedge clk); k++; end
    check("s1 first done", done1, 1'b1);
    check("s1 first result", {tt1, match1, mism1}, {16'h6996, 1'b1, 5'd0});
    expected1 = 16'h6997;
    errs = 0;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      if (j == 1 && (busy1 || done1)) errs++;
      if (j >= 2 && j <= 33 && (!busy1 || done1 || {a1, b1, c1, d1} != 4'((j - 2) / 2))) errs++;
    end
    check("s1 vector stepping", errs, 0);
    check("s1 done period 34", done1, 1'b1);
    check("s1 second result", {tt1, match1, mism1}, {16'h6996, 1'b0, 5'd1});
    start1 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
